// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//
// Fetch / decode / issue controller sitting directly in front of the
// register-file + ALU stage. One instruction is in flight at a time:
//
//   IDLE -> FETCH -> DECODE -> EXEC -> (FETCH | IDLE | HALT)
//
// Instruction word: [31:28] opcode, [27:24] rd, [23:20] rs1, [19:16] rs2,
//                   [15:0] imm (sign-extended or truncated to PC_WIDTH).
// Opcodes: 0x0-0x7 ALU (alu_ctrl = opcode[2:0], reg_write pulse),
//          0x8 BRZ (compare via BR_ALU_OP, taken when alu_zero),
//          0x9 JMP (pc-relative), 0xA-0xE NOP, 0xF HALT.
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous reset, active low
//   run         in   level enable; 0 parks the sequencer in IDLE
//   imem_req    out  fetch request (high throughout FETCH)
//   imem_addr   out  fetch word address (= pc)
//   imem_ack    in   fetch acknowledge, imem_rdata valid same cycle
//   imem_rdata  in   instruction word
//   read_reg1   out  rs1 to register file
//   read_reg2   out  rs2 to register file
//   write_reg   out  rd to register file
//   alu_ctrl    out  ALU operation select (valid in EXEC only)
//   reg_write   out  register-file write enable, one-cycle pulse in EXEC
//   alu_zero    in   ALU zero flag, sampled in EXEC
//   pc          out  current program counter
//   halted      out  high while in HALT
//   busy        out  high in FETCH, DECODE or EXEC
//   retired     out  (INSTR_RETIRE_COUNT_EN only) count of completed EXECs
//
// Optional feature: define INSTR_RETIRE_COUNT_EN to add the 32-bit
// retired-instruction counter and its output port.
// ---------------------------------------------------------------------------
module instr_sequencer #(
    parameter int unsigned           PC_WIDTH  = 16,
    parameter logic [PC_WIDTH-1:0]   RESET_PC  = '0,
    parameter logic [2:0]            BR_ALU_OP = 3'b001
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,
    output logic [3:0]          read_reg1,
    output logic [3:0]          read_reg2,
    output logic [3:0]          write_reg,
    output logic [2:0]          alu_ctrl,
    output logic                reg_write,
    input  logic                alu_zero,
    output logic [PC_WIDTH-1:0] pc,
    output logic                halted,
    output logic                busy
`ifdef INSTR_RETIRE_COUNT_EN
    ,
    output logic [31:0]         retired
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_BRZ  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t                state_q;
    logic [31:0]           ir_q;
    logic [PC_WIDTH-1:0]   pc_q;
    logic [PC_WIDTH-1:0]   pc_d;
    logic                  imem_req_q;
    logic [2:0]            alu_ctrl_q;
    logic                  reg_write_q;
`ifdef INSTR_RETIRE_COUNT_EN
    logic [31:0]           retired_q;
`endif

    logic [3:0]            opcode;
    logic [PC_WIDTH-1:0]   imm_ext;
    logic [PC_WIDTH-1:0]   pc_plus1;
    logic [PC_WIDTH-1:0]   pc_rel;
    logic [2:0]            dec_alu_ctrl;
    logic                  dec_reg_write;

    assign opcode = ir_q[31:28];

    // Immediate is widened with sign replication when the PC is wider than
    // 16 bits, otherwise only the low PC_WIDTH bits participate.
    generate
        if (PC_WIDTH > 16) begin : g_imm_sext
            assign imm_ext = {{(PC_WIDTH-16){ir_q[15]}}, ir_q[15:0]};
        end else begin : g_imm_trunc
            assign imm_ext = ir_q[PC_WIDTH-1:0];
        end
    endgenerate

    // Next-PC and issue controls decoded from the instruction register.
    // pc_q still holds the address of the instruction in EXEC, so relative
    // targets are taken from the branch/jump's own address.
    always_comb begin
        pc_plus1      = pc_q + PC_WIDTH'(1);
        pc_rel        = pc_q + imm_ext;
        pc_d          = pc_plus1;
        dec_alu_ctrl  = '0;
        dec_reg_write = 1'b0;

        case (opcode)
            OP_BRZ:  pc_d = alu_zero ? pc_rel : pc_plus1;
            OP_JMP:  pc_d = pc_rel;
            OP_HALT: pc_d = pc_q;
            default: pc_d = pc_plus1;
        endcase

        if (!opcode[3]) begin
            dec_alu_ctrl  = opcode[2:0];
            dec_reg_write = 1'b1;
        end else if (opcode == OP_BRZ) begin
            dec_alu_ctrl  = BR_ALU_OP;
        end
    end

    // Sequencer FSM with registered outputs. Each output register is loaded
    // on the edge that enters the state in which it must be valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            ir_q        <= '0;
            pc_q        <= RESET_PC;
            imem_req_q  <= 1'b0;
            alu_ctrl_q  <= '0;
            reg_write_q <= 1'b0;
`ifdef INSTR_RETIRE_COUNT_EN
            retired_q   <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run) begin
                        state_q    <= S_FETCH;
                        imem_req_q <= 1'b1;
                    end
                end

                S_FETCH: begin
                    // Ack only counts while a request is outstanding.
                    if (imem_req_q && imem_ack) begin
                        ir_q       <= imem_rdata;
                        imem_req_q <= 1'b0;
                        state_q    <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    alu_ctrl_q  <= dec_alu_ctrl;
                    reg_write_q <= dec_reg_write;
                    state_q     <= S_EXEC;
                end

                S_EXEC: begin
                    alu_ctrl_q  <= '0;
                    reg_write_q <= 1'b0;
                    pc_q        <= pc_d;
`ifdef INSTR_RETIRE_COUNT_EN
                    retired_q   <= retired_q + 32'd1;
`endif
                    if (opcode == OP_HALT) begin
                        state_q <= S_HALT;
                    end else if (run) begin
                        state_q    <= S_FETCH;
                        imem_req_q <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end

                S_HALT: begin
                    state_q <= S_HALT;
                end

                default: begin
                    state_q    <= S_IDLE;
                    imem_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Register selects come straight from the instruction register, which
    // only changes on a fetch ack, so they hold the last decoded fields.
    assign read_reg1 = ir_q[23:20];
    assign read_reg2 = ir_q[19:16];
    assign write_reg = ir_q[27:24];

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign alu_ctrl  = alu_ctrl_q;
    assign reg_write = reg_write_q;
    assign halted    = (state_q == S_HALT);
    assign busy      = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                       (state_q == S_EXEC);
`ifdef INSTR_RETIRE_COUNT_EN
    assign retired   = retired_q;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
//
// Directed bench for instr_sequencer: a small program walks through ALU,
// JMP (with PC wrap), taken/not-taken BRZ, delayed fetch ack and HALT,
// followed by an asynchronous reset during FETCH and a run drop mid
// instruction. Outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_instr_sequencer;

    localparam int unsigned PC_WIDTH = 16;

    logic                clk;
    logic                rst;
    logic                run;
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_ack;
    logic [31:0]         imem_rdata;
    logic [3:0]          read_reg1;
    logic [3:0]          read_reg2;
    logic [3:0]          write_reg;
    logic [2:0]          alu_ctrl;
    logic                reg_write;
    logic                alu_zero;
    logic [PC_WIDTH-1:0] pc;
    logic                halted;
    logic                busy;
`ifdef INSTR_RETIRE_COUNT_EN
    logic [31:0]         retired;
`endif

    logic [31:0] mem [0:65535];

    int checks;
    int errors;

    instr_sequencer #(
        .PC_WIDTH  (PC_WIDTH),
        .RESET_PC  (16'h0000),
        .BR_ALU_OP (3'b001)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .write_reg  (write_reg),
        .alu_ctrl   (alu_ctrl),
        .reg_write  (reg_write),
        .alu_zero   (alu_zero),
        .pc         (pc),
        .halted     (halted),
        .busy       (busy)
`ifdef INSTR_RETIRE_COUNT_EN
        ,
        .retired    (retired)
`endif
    );

    assign imem_rdata = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b0;
        run      = 1'b1;
        imem_ack = 1'b1;
        alu_zero = 1'b0;

        for (int i = 0; i < 65536; i++) mem[i] = 32'hA000_0000;
        mem[0]        = 32'h3210_0000; // ALU op3 rd=2 rs1=1 rs2=0
        mem[1]        = 32'h9000_FFFE; // JMP -2   -> 0xFFFF
        mem[16'hFFFF] = 32'h9000_0005; // JMP +5   -> 0x0004 (wrap)
        mem[4]        = 32'h8034_0005; // BRZ +5   rs1=3 rs2=4
        mem[9]        = 32'h9000_FFFB; // JMP -5   -> 0x0004
        mem[5]        = 32'hF000_0000; // HALT

        // Reset state
        tick(3);
        check_eq("rst_req",    imem_req,  0);
        check_eq("rst_pc",     pc,        0);
        check_eq("rst_halted", halted,    0);
        check_eq("rst_busy",   busy,      0);
        check_eq("rst_rr1",    read_reg1, 0);
        check_eq("rst_rr2",    read_reg2, 0);
        check_eq("rst_wr",     write_reg, 0);
        check_eq("rst_alu",    alu_ctrl,  0);
        check_eq("rst_we",     reg_write, 0);

        // IDLE -> FETCH
        rst = 1'b1;
        tick(1);
        check_eq("f0_req",    imem_req,  1);
        check_eq("f0_addr",   imem_addr, 0);
        check_eq("f0_pc",     pc,        0);
        check_eq("f0_halted", halted,    0);
        check_eq("f0_busy",   busy,      1);

        // ALU instruction at 0
        tick(1);
        check_eq("alu_dec_rr1", read_reg1, 1);
        check_eq("alu_dec_rr2", read_reg2, 0);
        check_eq("alu_dec_wr",  write_reg, 2);
        check_eq("alu_dec_req", imem_req,  0);
        check_eq("alu_dec_we",  reg_write, 0);
        tick(1);
        check_eq("alu_ex_ctrl", alu_ctrl,  3);
        check_eq("alu_ex_we",   reg_write, 1);
        check_eq("alu_ex_pc",   pc,        0);
        check_eq("alu_ex_rr1",  read_reg1, 1);
        tick(1);
        check_eq("alu_nx_pc",   pc,        1);
        check_eq("alu_nx_we",   reg_write, 0);
        check_eq("alu_nx_ctrl", alu_ctrl,  0);
        check_eq("alu_nx_req",  imem_req,  1);
        check_eq("alu_nx_addr", imem_addr, 1);

        // JMP wraps to 0xFFFF, then JMP +5 wraps to 4
        tick(2);
        check_eq("jmp_ex_we",   reg_write, 0);
        check_eq("jmp_ex_ctrl", alu_ctrl,  0);
        tick(1);
        check_eq("jmp_wrap_pc", pc, 16'hFFFF);
        tick(3);
        check_eq("jmp_fwd_pc",  pc, 4);

        // BRZ taken
        alu_zero = 1'b1;
        tick(1);
        check_eq("brz_dec_rr1", read_reg1, 3);
        check_eq("brz_dec_rr2", read_reg2, 4);
        check_eq("brz_dec_wr",  write_reg, 0);
        tick(1);
        check_eq("brz_ex_ctrl", alu_ctrl,  3'b001);
        check_eq("brz_ex_we",   reg_write, 0);
        tick(1);
        check_eq("brz_taken_pc", pc, 9);
        tick(3);
        check_eq("jmp_back_pc",  pc, 4);

        // BRZ not taken
        alu_zero = 1'b0;
        tick(2);
        check_eq("brz2_ex_ctrl", alu_ctrl,  3'b001);
        check_eq("brz2_ex_we",   reg_write, 0);
        tick(1);
        check_eq("brz_ntaken_pc", pc,       5);
        check_eq("halt_f1_req",   imem_req, 1);

        // Ack withheld two cycles, present on the third FETCH cycle
        imem_ack = 1'b0;
        tick(1);
        check_eq("halt_f2_req", imem_req, 1);
        tick(1);
        check_eq("halt_f3_req",  imem_req, 1);
        check_eq("halt_f3_busy", busy,     1);
        imem_ack = 1'b1;
        tick(1);
        check_eq("halt_dec_req",    imem_req, 0);
        check_eq("halt_dec_busy",   busy,     1);
        check_eq("halt_dec_halted", halted,   0);
        tick(1);
        check_eq("halt_ex_halted", halted,    0);
        check_eq("halt_ex_busy",   busy,      1);
        check_eq("halt_ex_we",     reg_write, 0);
        tick(1);
        check_eq("halt_halted", halted, 1);
        check_eq("halt_busy",   busy,   0);
`ifdef INSTR_RETIRE_COUNT_EN
        check_eq("halt_retired", retired, 7);
`endif
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check_eq("halt_hold_req",    imem_req, 0);
            check_eq("halt_hold_halted", halted,   1);
        end

        // Reset asserted mid-FETCH
        imem_ack = 1'b0;
        rst      = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(1);
        check_eq("rf_req_before", imem_req, 1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("rf_req_async", imem_req, 0);
        check_eq("rf_pc",        pc,       0);
        check_eq("rf_busy",      busy,     0);
        check_eq("rf_halted",    halted,   0);
`ifdef INSTR_RETIRE_COUNT_EN
        check_eq("rf_retired",   retired,  0);
`endif
        rst      = 1'b1;
        imem_ack = 1'b1;
        tick(1);
        check_eq("rr_req",  imem_req,  1);
        check_eq("rr_addr", imem_addr, 0);
        tick(1);
        // run drops during DECODE; the instruction still completes
        run = 1'b0;
        tick(1);
        check_eq("rd_ex_we",   reg_write, 1);
        check_eq("rd_ex_ctrl", alu_ctrl,  3);
        tick(1);
        check_eq("rd_pc",   pc,       1);
        check_eq("rd_req",  imem_req, 0);
        check_eq("rd_busy", busy,     0);
        check_eq("rd_we",   reg_write, 0);
`ifdef INSTR_RETIRE_COUNT_EN
        check_eq("rd_retired", retired, 1);
`endif
        // Idle with ack high: nothing is fetched
        tick(3);
        check_eq("idle_pc",   pc,       1);
        check_eq("idle_req",  imem_req, 0);
        check_eq("idle_busy", busy,     0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Fetch/decode/issue controller directly upstream of the register-file+ALU stage.
- Fetches 32-bit instruction words from instruction memory over a req/ack handshake and decodes register and ALU fields.
- Drives read_reg1/read_reg2/write_reg/alu_ctrl/reg_write for one instruction at a time, samples the ALU zero flag for branches, and maintains the PC.

Parameters:
- PC_WIDTH, 16, width of the program counter and imem_addr (word address).
- RESET_PC, 0, PC value loaded on reset.
- BR_ALU_OP, 3'b001, alu_ctrl value issued for BRZ compare (subtract).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous reset, active-low (0 = reset).
- run  input  1  level enable; 0 holds the sequencer in IDLE.
- imem_req  output  1  fetch request.
- imem_addr  output  PC_WIDTH  fetch word address (= pc).
- imem_ack  input  1  instruction-memory acknowledge; imem_rdata valid in the same cycle.
- imem_rdata  input  32  instruction word.
- read_reg1  output  4  rs1 to register file.
- read_reg2  output  4  rs2 to register file.
- write_reg  output  4  rd to register file.
- alu_ctrl  output  3  ALU operation select.
- reg_write  output  1  register-file write enable, one-cycle pulse.
- alu_zero  input  1  zero flag from ALU.
- pc  output  PC_WIDTH  current program counter.
- halted  output  1  high while in HALT.
- busy  output  1  high in FETCH, DECODE or EXEC.

Behaviour:
- Instruction format:
  - [31:28] opcode, [27:24] rd, [23:20] rs1, [19:16] rs2, [15:0] imm.
  - imm is sign-extended or truncated to PC_WIDTH.
- Opcodes:
  - 0x0-0x7 ALU: alu_ctrl=opcode[2:0], reg_write pulsed.
  - 0x8 BRZ: alu_ctrl=BR_ALU_OP, no write; if alu_zero then pc<=pc+imm, else pc+1.
  - 0x9 JMP: pc<=pc+imm, no ALU or write.
  - 0xF HALT.
  - 0xA-0xE NOP: pc+1.
- States: IDLE, FETCH, DECODE, EXEC, HALT.
  - IDLE: if run, go to FETCH next cycle.
  - FETCH: imem_req=1. On imem_ack, latch imem_rdata into the instruction register and go to DECODE. imem_req drops the cycle after ack.
  - DECODE: read_reg1/2 and write_reg are driven from the instruction register. They stay stable through EXEC. Go to EXEC.
  - EXEC: alu_ctrl driven; reg_write=1 for ALU ops only (exactly this one cycle); alu_zero sampled this cycle. PC updated at end of EXEC. Next state: FETCH if run=1, IDLE if run=0, HALT for opcode HALT.
  - HALT: absorbing; only reset exits.
- Latency: minimum 3 cycles per instruction (ack in first FETCH cycle); each cycle without ack adds one.
- Output defaults outside their active states:
  - alu_ctrl=0, reg_write=0, imem_req=0.
  - read/write reg outputs keep the last decoded value.
- Reset values: state=IDLE, pc=RESET_PC, instruction register=0, all reg/ctrl outputs 0, imem_req=0, halted=0, busy=0.
- Boundaries:
  - PC arithmetic wraps modulo 2^PC_WIDTH.
  - Branch target is relative to the branch instruction's own address.
  - imem_ack while imem_req=0 is ignored.
  - run dropping mid-instruction does not abort; the current instruction completes.
  - Reset asserted mid-FETCH drops imem_req immediately (asynchronous).
  - rd=0 is written like any other register; no special casing here.

Optional Feature:
- Macro INSTR_RETIRE_COUNT_EN adds output retired[31:0].
  - Reset 0; increments by 1 at the end of each EXEC (including NOP, JMP, BRZ and HALT).
  - Wraps at 2^32.
- Without the macro, the port and counter do not exist.

Test Plan:
- Reset with rst=0, then release with run=1, imem_ack tied 1 -> imem_req=1 with imem_addr=0 on first FETCH; pc=0, halted=0.
- Word 0x3210_0000 (opcode 3, rd=2, rs1=1, rs2=0) with ack in the first cycle:
  - DECODE drives read_reg1=1, read_reg2=0, write_reg=2.
  - Next cycle: alu_ctrl=3, reg_write=1 for exactly one cycle; pc becomes 1.
- BRZ 0x8034_0005 at pc=4:
  - alu_zero=1 -> pc=9, reg_write stays 0, alu_ctrl=BR_ALU_OP.
  - Repeat with alu_zero=0 -> pc=5.
- JMP 0x9000_FFFE at pc=1 -> pc=0xFFFF (wrap, PC_WIDTH=16).
- Ack delayed 3 cycles -> imem_req held high 3 cycles, then exactly one DECODE; HALT 0xF000_0000 -> halted=1, imem_req stays 0 for 20 cycles.
- Assert rst=0 during FETCH -> imem_req=0 before the next edge, pc=RESET_PC; with INSTR_RETIRE_COUNT_EN, retired=0, then 1 after the next EXEC.
